icache_req_arbiter: RTL and testbench

Sequences the single ICache request port between the fetch-stage demand stream and a next-line prefetcher. It tracks the one outstanding ICache request, replays it on timeout, and kills it on flush or redirect. It also owns a one-entry prefetch line buffer that serves demand hits without an ICache access. It sits between fetch and the ICache interface logic and handles all ICache req/kill/resp traffic.

---
 rtl/icache_req_arbiter_pkg.sv | 23 ++
 rtl/icache_req_arbiter_if.sv | 25 ++
 rtl/icache_prefetch_buffer.sv | 40 ++++
 rtl/icache_req_arbiter.sv | 246 ++++++++++++++++++++++++
 tb/tb_icache_req_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_req_arbiter_pkg.sv
// Shared types and constants for the ICache request arbiter.
package icache_req_arbiter_pkg;

    localparam int ICACHE_ADDR_SIZE  = 40;
    localparam int ICACHE_LINE_BITS  = 128;
    localparam int LINE_OFFSET_W     = 4;
    localparam int ICACHE_LINE_TAG_W = ICACHE_ADDR_SIZE - LINE_OFFSET_W;

    typedef logic [ICACHE_LINE_TAG_W-1:0] icache_line_tag_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DMD_WAIT = 2'd1,
        PF_WAIT  = 2'd2,
        DRAIN    = 2'd3
    } icache_arb_state_t;

    // The next line would fall into the following 4 KiB page.
    function automatic logic crosses_page(input logic [7:0] tag_lo);
        return tag_lo == 8'hFF;
    endfunction

endpackage

// File: rtl/icache_req_arbiter_if.sv
// ICache request/kill/response bundle between the arbiter (master) and the ICache logic (slave).
interface icache_req_arbiter_if
    import icache_req_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = ICACHE_ADDR_SIZE,
    parameter int LINE_BITS = ICACHE_LINE_BITS
);
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_SIZE-1:0] req_vaddr;
    logic                 req_kill;
    logic                 resp_valid;
    logic [ADDR_SIZE-1:0] resp_vaddr;
    logic [LINE_BITS-1:0] resp_line;

    modport master (
        output req_valid, req_vaddr, req_kill,
        input  req_ready, resp_valid, resp_vaddr, resp_line
    );

    modport slave (
        input  req_valid, req_vaddr, req_kill,
        output req_ready, resp_valid, resp_vaddr, resp_line
    );
endinterface

// File: rtl/icache_prefetch_buffer.sv
// Single-entry prefetch line buffer: one valid/tag/line entry with fill, clear and lookup.
module icache_prefetch_buffer
    import icache_req_arbiter_pkg::*;
#(
    parameter int TAG_W     = ICACHE_LINE_TAG_W,
    parameter int LINE_BITS = ICACHE_LINE_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 fill,
    input  logic [TAG_W-1:0]     fill_tag,
    input  logic [LINE_BITS-1:0] fill_line,
    input  logic                 clear,
    input  logic [TAG_W-1:0]     lookup_tag,
    output logic                 hit,
    output logic [LINE_BITS-1:0] line
);
    logic                 valid_reg;
    logic [TAG_W-1:0]     tag_reg;
    logic [LINE_BITS-1:0] line_reg;

    // Entry update; a clear in the same cycle as a fill wins so stale data never survives a flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            line_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (fill) begin
            valid_reg <= 1'b1;
            tag_reg   <= fill_tag;
            line_reg  <= fill_line;
        end
    end

    assign hit  = valid_reg && (tag_reg == lookup_tag);
    assign line = line_reg;

endmodule

// File: rtl/icache_req_arbiter.sv
// Arbitrates the single ICache request port between fetch demands and a next-line prefetcher,
// tracking one outstanding request with timeout replay, kill on flush/redirect, and a
// one-entry prefetch buffer that answers demand hits without touching the ICache.
module icache_req_arbiter
    import icache_req_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = ICACHE_ADDR_SIZE,
    parameter int LINE_BITS = ICACHE_LINE_BITS,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dmd_valid_i,
    input  logic [ADDR_SIZE-1:0] dmd_vaddr_i,
    input  logic                 dmd_flush_i,
    output logic                 dmd_ready_o,
    output logic                 dmd_resp_valid_o,
    output logic [LINE_BITS-1:0] dmd_resp_line_o,
    output logic [ADDR_SIZE-1:0] dmd_resp_vaddr_o,
    input  logic                 pf_enable_i,
    icache_req_arbiter_if.master ic
);
    localparam int TAG_W = ADDR_SIZE - LINE_OFFSET_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    icache_arb_state_t    state_reg, state_next;
    logic [TAG_W-1:0]     tag_reg, tag_next;
    logic [TAG_W-1:0]     pf_tag_reg, pf_tag_next;
    logic                 pf_pending_reg, pf_pending_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [ADDR_SIZE-1:0] dmd_vaddr_reg, dmd_vaddr_next;
    logic                 resp_valid_reg, resp_valid_next;
    logic [LINE_BITS-1:0] resp_line_reg, resp_line_next;
    logic [ADDR_SIZE-1:0] resp_vaddr_reg, resp_vaddr_next;

    logic [TAG_W-1:0]         dmd_tag;
    logic [TAG_W-1:0]         resp_tag;
    logic [LINE_OFFSET_W-1:0] resp_offset_unused;
    logic                     resp_match;
    logic                     timed_out;

    logic                 buf_hit;
    logic [LINE_BITS-1:0] buf_line;
    logic                 buf_fill;
    logic                 buf_clear;

    logic             ic_req_valid;
    logic [TAG_W-1:0] ic_req_tag;
    logic             ic_req_kill;
    logic             dmd_ready;
    logic             sel_dmd;
    logic             sel_pf;
    logic             serve_hit;

    assign dmd_tag            = dmd_vaddr_i[ADDR_SIZE-1:LINE_OFFSET_W];
    assign resp_tag           = ic.resp_vaddr[ADDR_SIZE-1:LINE_OFFSET_W];
    assign resp_offset_unused = ic.resp_vaddr[LINE_OFFSET_W-1:0];
    assign resp_match         = ic.resp_valid && (resp_tag == tag_reg);
    assign timed_out          = (cnt_reg == CNT_W'(TIMEOUT));

    icache_prefetch_buffer #(
        .TAG_W     (TAG_W),
        .LINE_BITS (LINE_BITS)
    ) u_pf_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .fill       (buf_fill),
        .fill_tag   (tag_reg),
        .fill_line  (ic.resp_line),
        .clear      (buf_clear),
        .lookup_tag (dmd_tag),
        .hit        (buf_hit),
        .line       (buf_line)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Tracking registers: outstanding tag, prefetch candidate, timeout counter and demand response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_reg        <= '0;
            pf_tag_reg     <= '0;
            pf_pending_reg <= 1'b0;
            cnt_reg        <= '0;
            dmd_vaddr_reg  <= '0;
            resp_valid_reg <= 1'b0;
            resp_line_reg  <= '0;
            resp_vaddr_reg <= '0;
        end else begin
            tag_reg        <= tag_next;
            pf_tag_reg     <= pf_tag_next;
            pf_pending_reg <= pf_pending_next;
            cnt_reg        <= cnt_next;
            dmd_vaddr_reg  <= dmd_vaddr_next;
            resp_valid_reg <= resp_valid_next;
            resp_line_reg  <= resp_line_next;
            resp_vaddr_reg <= resp_vaddr_next;
        end
    end

    // Next-state and tracking-register update logic.
    always_comb begin
        state_next      = state_reg;
        tag_next        = tag_reg;
        pf_tag_next     = pf_tag_reg;
        pf_pending_next = pf_pending_reg;
        dmd_vaddr_next  = dmd_vaddr_reg;
        cnt_next        = (state_reg != IDLE && !timed_out) ? cnt_reg + 1'b1 : cnt_reg;
        resp_valid_next = 1'b0;
        resp_line_next  = resp_line_reg;
        resp_vaddr_next = resp_vaddr_reg;

        case (state_reg)
            IDLE: begin
                if (serve_hit) begin
                    resp_valid_next = 1'b1;
                    resp_line_next  = buf_line;
                    resp_vaddr_next = dmd_vaddr_i;
                end else if (sel_dmd && ic.req_ready) begin
                    state_next     = DMD_WAIT;
                    tag_next       = dmd_tag;
                    dmd_vaddr_next = dmd_vaddr_i;
                    cnt_next       = '0;
                end else if (sel_pf && ic.req_ready) begin
                    state_next      = PF_WAIT;
                    tag_next        = pf_tag_reg;
                    pf_pending_next = 1'b0;
                    cnt_next        = '0;
                end
            end
            DMD_WAIT: begin
                if (dmd_flush_i) begin
                    // A response landing together with the flush is dropped and nothing is left to drain.
                    state_next = resp_match ? IDLE : DRAIN;
                    cnt_next   = '0;
                end else if (resp_match) begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b1;
                    resp_line_next  = ic.resp_line;
                    resp_vaddr_next = dmd_vaddr_reg;
                    pf_tag_next     = tag_reg + 1'b1;
                    pf_pending_next = !crosses_page(tag_reg[7:0]);
                end else if (ic_req_valid && ic.req_ready) begin
                    cnt_next = '0;
                end
            end
            PF_WAIT: begin
                if (dmd_flush_i) begin
                    state_next = resp_match ? IDLE : DRAIN;
                    cnt_next   = '0;
                end else if (resp_match) begin
                    state_next = IDLE;
                end else if (dmd_valid_i) begin
                    if (dmd_tag == tag_reg) begin
                        // The prefetch already in flight becomes the demand; its timer keeps running.
                        state_next     = DMD_WAIT;
                        dmd_vaddr_next = dmd_vaddr_i;
                    end else begin
                        state_next = DRAIN;
                        cnt_next   = '0;
                    end
                end
            end
            DRAIN: begin
                if (ic.resp_valid || timed_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (dmd_flush_i) begin
            pf_pending_next = 1'b0;
        end
    end

    // Output decode: request/kill/ready strobes and prefetch-buffer control.
    always_comb begin
        ic_req_valid = 1'b0;
        ic_req_tag   = tag_reg;
        ic_req_kill  = 1'b0;
        dmd_ready    = 1'b0;
        sel_dmd      = 1'b0;
        sel_pf       = 1'b0;
        serve_hit    = 1'b0;
        buf_fill     = 1'b0;
        buf_clear    = 1'b0;

        if (!rst_i) begin
            buf_clear = dmd_flush_i;
            case (state_reg)
                IDLE: begin
                    if (!dmd_flush_i) begin
                        dmd_ready = buf_hit || ic.req_ready;
                        if (dmd_valid_i && buf_hit) begin
                            serve_hit = 1'b1;
                            buf_clear = 1'b1;
                        end else if (dmd_valid_i) begin
                            sel_dmd      = 1'b1;
                            ic_req_valid = 1'b1;
                            ic_req_tag   = dmd_tag;
                        end else if (pf_enable_i && pf_pending_reg) begin
                            sel_pf       = 1'b1;
                            ic_req_valid = 1'b1;
                            ic_req_tag   = pf_tag_reg;
                        end
                    end
                end
                DMD_WAIT: begin
                    if (dmd_flush_i) begin
                        ic_req_kill = 1'b1;
                    end else if (!resp_match && timed_out) begin
                        ic_req_valid = 1'b1;
                    end
                end
                PF_WAIT: begin
                    if (dmd_flush_i) begin
                        ic_req_kill = 1'b1;
                    end else if (resp_match) begin
                        buf_fill = 1'b1;
                    end else if (dmd_valid_i && (dmd_tag != tag_reg)) begin
                        ic_req_kill = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ic.req_valid = ic_req_valid;
    assign ic.req_vaddr = {ic_req_tag, {LINE_OFFSET_W{1'b0}}};
    assign ic.req_kill  = ic_req_kill;

    assign dmd_ready_o      = dmd_ready;
    assign dmd_resp_valid_o = resp_valid_reg;
    assign dmd_resp_line_o  = resp_line_reg;
    assign dmd_resp_vaddr_o = resp_vaddr_reg;

endmodule

// File: tb/tb_icache_req_arbiter.sv
// Directed bench for icache_req_arbiter: drives fetch/ICache traffic cycle by cycle and
// scoreboards every demand response against the line the bench itself expects.
module tb_icache_req_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         dmd_valid_i;
    logic [39:0]  dmd_vaddr_i;
    logic         dmd_flush_i;
    logic         dmd_ready_o;
    logic         dmd_resp_valid_o;
    logic [127:0] dmd_resp_line_o;
    logic [39:0]  dmd_resp_vaddr_o;
    logic         pf_enable_i;

    icache_req_arbiter_if #(.ADDR_SIZE(40), .LINE_BITS(128)) ic ();

    icache_req_arbiter #(.ADDR_SIZE(40), .LINE_BITS(128), .TIMEOUT(64)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dmd_valid_i      (dmd_valid_i),
        .dmd_vaddr_i      (dmd_vaddr_i),
        .dmd_flush_i      (dmd_flush_i),
        .dmd_ready_o      (dmd_ready_o),
        .dmd_resp_valid_o (dmd_resp_valid_o),
        .dmd_resp_line_o  (dmd_resp_line_o),
        .dmd_resp_vaddr_o (dmd_resp_vaddr_o),
        .pf_enable_i      (pf_enable_i),
        .ic               (ic)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [39:0]  vaddr;
        logic [127:0] line;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [127:0] line_of(input logic [35:0] tag);
        return {tag[31:0] ^ 32'hDEADBEEF, tag[31:0], ~tag[31:0], {28'h0, tag[35:32]}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic respond(input logic [39:0] va);
        ic.resp_valid = 1'b1;
        ic.resp_vaddr = va;
        ic.resp_line  = line_of(va[39:4]);
    endtask

    task automatic resp_off();
        ic.resp_valid = 1'b0;
    endtask

    task automatic push(input logic [39:0] va);
        exp_t e;
        e.vaddr = va;
        e.line  = line_of(va[39:4]);
        exp_q.push_back(e);
    endtask

    task automatic demand(input logic [39:0] va);
        dmd_valid_i = 1'b1;
        dmd_vaddr_i = va;
    endtask

    // Response monitor: every dmd_resp_valid_o pulse must match the oldest expected demand.
    always @(negedge clk_i) begin
        if (!rst_i && dmd_resp_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 128'(dmd_resp_valid_o), 128'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("resp  vaddr=%h line=%h", dmd_resp_vaddr_o, dmd_resp_line_o);
                chk("resp_vaddr", 128'(dmd_resp_vaddr_o), 128'(e.vaddr));
                chk("resp_line", dmd_resp_line_o, e.line);
            end
        end
    end

    initial begin
        int first;

        rst_i         = 1'b1;
        dmd_valid_i   = 1'b1;
        dmd_vaddr_i   = 40'h80000000;
        dmd_flush_i   = 1'b0;
        pf_enable_i   = 1'b1;
        ic.req_ready  = 1'b1;
        ic.resp_valid = 1'b0;
        ic.resp_vaddr = '0;
        ic.resp_line  = '0;

        // Reset: every output low even with a demand presented.
        repeat (3) step();
        chk("rst_req_valid", 128'(ic.req_valid), 128'd0);
        chk("rst_kill", 128'(ic.req_kill), 128'd0);
        chk("rst_dmd_ready", 128'(dmd_ready_o), 128'd0);
        chk("rst_resp_valid", 128'(dmd_resp_valid_o), 128'd0);
        chk("rst_resp_line", dmd_resp_line_o, 128'd0);
        chk("rst_resp_vaddr", 128'(dmd_resp_vaddr_o), 128'd0);
        rst_i       = 1'b0;
        dmd_valid_i = 1'b0;
        step();

        // Demand miss, 5-cycle ICache latency, followed by a next-line prefetch.
        demand(40'h80001000);
        settle();
        $display("req   demand vaddr=%h", dmd_vaddr_i);
        chk("miss_req_valid", 128'(ic.req_valid), 128'd1);
        chk("miss_req_vaddr", 128'(ic.req_vaddr), 128'h80001000);
        chk("miss_dmd_ready", 128'(dmd_ready_o), 128'd1);
        push(40'h80001000);
        step();
        dmd_valid_i = 1'b0;
        settle();
        chk("wait_req_valid", 128'(ic.req_valid), 128'd0);
        repeat (4) step();
        respond(40'h80001000);
        step();
        resp_off();
        settle();
        chk("miss_resp_cycle6", 128'(dmd_resp_valid_o), 128'd1);
        chk("pf_req_valid", 128'(ic.req_valid), 128'd1);
        chk("pf_req_vaddr", 128'(ic.req_vaddr), 128'h80001010);
        step();
        respond(40'h80001010);
        step();
        resp_off();
        settle();
        chk("pf_done_idle", 128'(ic.req_valid), 128'd0);

        // Prefetch buffer hit: answered next cycle with no ICache request, then buffer empties.
        demand(40'h80001010);
        settle();
        $display("req   demand vaddr=%h (buffer)", dmd_vaddr_i);
        chk("hit_no_req", 128'(ic.req_valid), 128'd0);
        chk("hit_dmd_ready", 128'(dmd_ready_o), 128'd1);
        push(40'h80001010);
        step();
        chk("hit_resp_1cyc", 128'(dmd_resp_valid_o), 128'd1);
        ic.req_ready = 1'b0;
        settle();
        chk("hit_buf_cleared", 128'(ic.req_valid), 128'd1);
        chk("hit_ready_low", 128'(dmd_ready_o), 128'd0);
        dmd_valid_i  = 1'b0;
        ic.req_ready = 1'b1;
        step();

        // Redirecting demand during a prefetch: kill, drain the stale response, then issue.
        demand(40'h80001000);
        settle();
        $display("req   demand vaddr=%h", dmd_vaddr_i);
        push(40'h80001000);
        step();
        dmd_valid_i = 1'b0;
        respond(40'h80001000);
        step();
        resp_off();
        settle();
        chk("pf2_req_vaddr", 128'(ic.req_vaddr), 128'h80001010);
        step();
        demand(40'h80002000);
        settle();
        chk("redir_kill", 128'(ic.req_kill), 128'd1);
        chk("redir_no_req", 128'(ic.req_valid), 128'd0);
        step();
        chk("drain_kill_off", 128'(ic.req_kill), 128'd0);
        chk("drain_not_ready", 128'(dmd_ready_o), 128'd0);
        respond(40'h80001010);
        step();
        resp_off();
        settle();
        chk("redir_issue_valid", 128'(ic.req_valid), 128'd1);
        chk("redir_issue_vaddr", 128'(ic.req_vaddr), 128'h80002000);
        $display("req   demand vaddr=%h", dmd_vaddr_i);
        push(40'h80002000);
        step();
        dmd_valid_i = 1'b0;
        respond(40'h80002000);
        step();
        resp_off();
        settle();
        chk("pf3_req_vaddr", 128'(ic.req_vaddr), 128'h80002010);

        // Flush in DMD_WAIT with a response in the same cycle: kill, nothing returned, back to IDLE.
        demand(40'h80003000);
        settle();
        $display("req   demand vaddr=%h (flushed)", dmd_vaddr_i);
        chk("dmd_over_pf", 128'(ic.req_vaddr), 128'h80003000);
        step();
        dmd_valid_i = 1'b0;
        step();
        dmd_flush_i = 1'b1;
        respond(40'h80003000);
        settle();
        chk("flush_kill", 128'(ic.req_kill), 128'd1);
        step();
        dmd_flush_i = 1'b0;
        resp_off();
        settle();
        chk("flush_to_idle", 128'(dmd_ready_o), 128'd1);
        chk("flush_no_resp", 128'(dmd_resp_valid_o), 128'd0);
        chk("flush_pf_cleared", 128'(ic.req_valid), 128'd0);

        // Timeout replay: no response, so the same line is requested again.
        demand(40'h80004000);
        settle();
        $display("req   demand vaddr=%h (timeout)", dmd_vaddr_i);
        step();
        dmd_valid_i = 1'b0;
        first = -1;
        for (int c = 1; c <= 100 && first < 0; c++) begin
            if (ic.req_valid) first = c;
            else step();
        end
        chk("replay_cycle", 128'(first), 128'd65);
        chk("replay_vaddr", 128'(ic.req_vaddr), 128'h80004000);
        step();
        chk("replay_accepted", 128'(ic.req_valid), 128'd0);
        respond(40'h80004000);
        push(40'h80004000);
        step();
        resp_off();

        // Last line of a page: served, and no prefetch crosses into the next page.
        demand(40'h80001FF0);
        settle();
        $display("req   demand vaddr=%h", dmd_vaddr_i);
        chk("page_req_vaddr", 128'(ic.req_vaddr), 128'h80001FF0);
        push(40'h80001FF0);
        step();
        dmd_valid_i = 1'b0;
        step();
        respond(40'h80001FF0);
        step();
        resp_off();
        settle();
        chk("page_no_pf", 128'(ic.req_valid), 128'd0);

        // Demand matching the in-flight prefetch is promoted without a new request.
        demand(40'h80005000);
        settle();
        $display("req   demand vaddr=%h", dmd_vaddr_i);
        push(40'h80005000);
        step();
        dmd_valid_i = 1'b0;
        respond(40'h80005000);
        step();
        resp_off();
        settle();
        chk("pf5_req_vaddr", 128'(ic.req_vaddr), 128'h80005010);
        step();
        demand(40'h80005018);
        settle();
        $display("req   demand vaddr=%h (promoted)", dmd_vaddr_i);
        chk("promote_no_req", 128'(ic.req_valid), 128'd0);
        chk("promote_no_kill", 128'(ic.req_kill), 128'd0);
        push(40'h80005018);
        step();
        dmd_valid_i = 1'b0;
        respond(40'h80005010);
        step();
        resp_off();
        step();
        chk("promote_next_pf", 128'(ic.req_vaddr), 128'h80005020);
        pf_enable_i = 1'b0;
        settle();
        chk("pf_disabled", 128'(ic.req_valid), 128'd0);

        repeat (3) step();
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
